// File: rtl/i2s_pkg.sv
// Shared constants and state type for the I2S target endpoint.
package i2s_pkg;

   localparam int SAMPLE_W_DEF = 24;
   localparam int SLOT_MAX_DEF = 32;

   localparam logic CH_LEFT  = 1'b0;
   localparam logic CH_RIGHT = 1'b1;

   typedef enum logic {
      UNSYNC = 1'b0,
      RUN    = 1'b1
   } state_e;

endpackage

// File: rtl/i2s_pin_sync.sv
// Two-flop synchronizer for the asynchronous I2S pins. The edge pin also keeps
// a delayed copy so one-cycle rise/fall events can be derived from it.
module i2s_pin_sync #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         edge_pin,
   input  logic [W-1:0] data_pin,
   output logic [W-1:0] data_sync,
   output logic         rise,
   output logic         fall
);

   logic [W:0] meta_q, meta_d;
   logic [W:0] sync_q, sync_d;
   logic       prev_q, prev_d;

   always_comb begin
      meta_d = {data_pin, edge_pin};
      sync_d = meta_q;
      prev_d = sync_q[0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= '0;
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign data_sync = sync_q[W:1];
   assign rise      = sync_q[0] & ~prev_q;
   assign fall      = ~sync_q[0] & prev_q;

endmodule

// File: rtl/i2s_target.sv
// I2S target endpoint: oversamples SCLK/LRCLK/SDIN in the clk domain, deserializes
// received words and serializes TX words. Optional feature macro: I2S_TARGET_LOOPBACK_EN.
module i2s_target
   import i2s_pkg::*;
#(
   parameter int SAMPLE_W = SAMPLE_W_DEF,
   parameter int SLOT_MAX = SLOT_MAX_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                sclk,
   input  logic                lrclk,
   input  logic                sdin,
`ifdef I2S_TARGET_LOOPBACK_EN
   input  logic                loopback,
`endif
   output logic                sdout,
   output logic [SAMPLE_W-1:0] rx_data,
   output logic                rx_ch,
   output logic                rx_vld,
   output logic                rx_short,
   input  logic [SAMPLE_W-1:0] tx_data0,
   input  logic [SAMPLE_W-1:0] tx_data1,
   output logic [1:0]          tx_ack,
   output logic                synced
);

   localparam int CNT_W = $clog2(SLOT_MAX + 1);
   localparam int TXC_W = $clog2(SAMPLE_W + 1);
   localparam logic [CNT_W-1:0] SAMPLE_W_C = CNT_W'(SAMPLE_W);
   localparam logic [CNT_W-1:0] SLOT_MAX_C = CNT_W'(SLOT_MAX);
   localparam logic [TXC_W-1:0] TX_BITS_C  = TXC_W'(SAMPLE_W);

   logic [1:0]          pins_sync;
   logic                lr_sync, bit_s, sclk_rise, sclk_fall, boundary;

   state_e              state_q, state_d;
   logic                lr_s_q, lr_s_d;
   logic [SAMPLE_W-1:0] rx_sh_q, rx_sh_d;
   logic [CNT_W-1:0]    bitcnt_q, bitcnt_d;
   logic [SAMPLE_W-1:0] rx_data_q, rx_data_d;
   logic                rx_ch_q, rx_ch_d;
   logic                rx_vld_q, rx_vld_d;
   logic                rx_short_q, rx_short_d;
   logic [SAMPLE_W-1:0] tx_sh_q, tx_sh_d;
   logic [TXC_W-1:0]    tx_rem_q, tx_rem_d;
   logic                sdout_q, sdout_d;
   logic [1:0]          tx_ack_q, tx_ack_d;
`ifdef I2S_TARGET_LOOPBACK_EN
   logic [1:0][SAMPLE_W-1:0] lb_q, lb_d;
`endif

   i2s_pin_sync #(.W(2)) u_pin_sync (
      .clk       (clk),
      .rst       (rst),
      .edge_pin  (sclk),
      .data_pin  ({sdin, lrclk}),
      .data_sync (pins_sync),
      .rise      (sclk_rise),
      .fall      (sclk_fall)
   );

   assign lr_sync = pins_sync[0];
   assign bit_s   = pins_sync[1];

   always_comb begin
      state_d    = state_q;
      lr_s_d     = lr_s_q;
      rx_sh_d    = rx_sh_q;
      bitcnt_d   = bitcnt_q;
      rx_data_d  = rx_data_q;
      rx_ch_d    = rx_ch_q;
      rx_vld_d   = 1'b0;
      rx_short_d = 1'b0;
      tx_sh_d    = tx_sh_q;
      tx_rem_d   = tx_rem_q;
      sdout_d    = sdout_q;
      tx_ack_d   = 2'b00;
`ifdef I2S_TARGET_LOOPBACK_EN
      lb_d       = lb_q;
`endif
      boundary   = sclk_rise && (lr_sync != lr_s_q);

      if (sclk_rise) begin
         lr_s_d = lr_sync;
         if (state_q == RUN) begin
            for (int i = 0; i < SAMPLE_W; i++) begin
               if (bitcnt_q == CNT_W'(SAMPLE_W - 1 - i)) rx_sh_d[i] = bit_s;
            end
            if (bitcnt_q < SLOT_MAX_C) bitcnt_d = bitcnt_q + CNT_W'(1);
            // The boundary rise still carries the ending word's last bit (I2S one-bit delay).
            if (boundary) begin
               rx_data_d  = rx_sh_d;
               rx_ch_d    = lr_s_q;
               rx_vld_d   = 1'b1;
               rx_short_d = (bitcnt_d < SAMPLE_W_C);
`ifdef I2S_TARGET_LOOPBACK_EN
               lb_d[lr_s_q] = rx_sh_d;
`endif
            end
         end
         if (boundary) begin
            state_d  = RUN;
            rx_sh_d  = '0;
            bitcnt_d = '0;
            tx_rem_d = TX_BITS_C;
            tx_sh_d  = (lr_sync == CH_RIGHT) ? tx_data1 : tx_data0;
            tx_ack_d = (lr_sync == CH_RIGHT) ? 2'b10 : 2'b01;
`ifdef I2S_TARGET_LOOPBACK_EN
            if (loopback) begin
               tx_sh_d  = lb_q[lr_sync];
               tx_ack_d = 2'b00;
            end
`endif
         end
      end

      if (sclk_fall) begin
         if (tx_rem_q != '0) begin
            sdout_d  = tx_sh_q[SAMPLE_W-1];
            tx_sh_d  = tx_sh_q << 1;
            tx_rem_d = tx_rem_q - TXC_W'(1);
         end else begin
            sdout_d  = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= UNSYNC;
         lr_s_q     <= 1'b0;
         rx_sh_q    <= '0;
         bitcnt_q   <= '0;
         rx_data_q  <= '0;
         rx_ch_q    <= 1'b0;
         rx_vld_q   <= 1'b0;
         rx_short_q <= 1'b0;
         tx_sh_q    <= '0;
         tx_rem_q   <= '0;
         sdout_q    <= 1'b0;
         tx_ack_q   <= 2'b00;
`ifdef I2S_TARGET_LOOPBACK_EN
         lb_q       <= '0;
`endif
      end else begin
         state_q    <= state_d;
         lr_s_q     <= lr_s_d;
         rx_sh_q    <= rx_sh_d;
         bitcnt_q   <= bitcnt_d;
         rx_data_q  <= rx_data_d;
         rx_ch_q    <= rx_ch_d;
         rx_vld_q   <= rx_vld_d;
         rx_short_q <= rx_short_d;
         tx_sh_q    <= tx_sh_d;
         tx_rem_q   <= tx_rem_d;
         sdout_q    <= sdout_d;
         tx_ack_q   <= tx_ack_d;
`ifdef I2S_TARGET_LOOPBACK_EN
         lb_q       <= lb_d;
`endif
      end
   end

   assign sdout    = sdout_q;
   assign rx_data  = rx_data_q;
   assign rx_ch    = rx_ch_q;
   assign rx_vld   = rx_vld_q;
   assign rx_short = rx_short_q;
   assign tx_ack   = tx_ack_q;
   assign synced   = (state_q == RUN);

endmodule

// File: tb/tb_i2s_target.sv
// Bench for i2s_target: an I2S controller model drives the pins, and a word-level
// reference model predicts received words, acks and the words captured from sdout.
`timescale 1ns/1ps
module tb_i2s_target;

   localparam int SW = 24;

   logic          clk, rst, sclk, lrclk, sdin;
   logic [SW-1:0] tx_data0, tx_data1;
   logic          sdout, rx_ch, rx_vld, rx_short, synced;
   logic [SW-1:0] rx_data;
   logic [1:0]    tx_ack;
`ifdef I2S_TARGET_LOOPBACK_EN
   logic          loopback;
`endif

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic          ch;
      logic          short_f;
      logic [SW-1:0] data;
   } rx_ev_t;

   rx_ev_t     obs_rx[$], exp_rx[$];
   logic [1:0] obs_ack[$], exp_ack[$];
   bit         sdout_seen;

   // Controller/model state
   logic          next_ch, last_lr, pending, prev_ch;
   bit            m_synced, lb_on, cap_valid;
   int            prev_n, cap_n;
   logic [31:0]   prev_bits, cap, cap_exp;
   logic [SW-1:0] lb_m [2];

   i2s_target #(.SAMPLE_W(SW), .SLOT_MAX(32)) dut (
      .clk      (clk),
      .rst      (rst),
      .sclk     (sclk),
      .lrclk    (lrclk),
      .sdin     (sdin),
`ifdef I2S_TARGET_LOOPBACK_EN
      .loopback (loopback),
`endif
      .sdout    (sdout),
      .rx_data  (rx_data),
      .rx_ch    (rx_ch),
      .rx_vld   (rx_vld),
      .rx_short (rx_short),
      .tx_data0 (tx_data0),
      .tx_data1 (tx_data1),
      .tx_ack   (tx_ack),
      .synced   (synced)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rx_vld || rx_short) obs_rx.push_back({rx_ch, rx_short, rx_data});
      if (tx_ack != 2'b00) obs_ack.push_back(tx_ack);
      if (sdout) sdout_seen = 1'b1;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [31:0] slot_mask(input int n);
      return (n >= 32) ? 32'hFFFF_FFFF : ~(32'hFFFF_FFFF >> n);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_sdout"},    32'(sdout),    32'd0);
      check({tag, "_rx_data"},  32'(rx_data),  32'd0);
      check({tag, "_rx_ch"},    32'(rx_ch),    32'd0);
      check({tag, "_rx_vld"},   32'(rx_vld),   32'd0);
      check({tag, "_rx_short"}, 32'(rx_short), 32'd0);
      check({tag, "_tx_ack"},   32'(tx_ack),   32'd0);
      check({tag, "_synced"},   32'(synced),   32'd0);
   endtask

   task automatic check_queues(input string tag);
      rx_ev_t     o, e;
      logic [1:0] oa, ea;
      check({tag, "_rx_count"}, 32'(obs_rx.size()), 32'(exp_rx.size()));
      while (obs_rx.size() > 0 && exp_rx.size() > 0) begin
         o = obs_rx.pop_front();
         e = exp_rx.pop_front();
         check({tag, "_rx_event"}, 32'(o), 32'(e));
      end
      obs_rx.delete();
      exp_rx.delete();
      check({tag, "_ack_count"}, 32'(obs_ack.size()), 32'(exp_ack.size()));
      while (obs_ack.size() > 0 && exp_ack.size() > 0) begin
         oa = obs_ack.pop_front();
         ea = exp_ack.pop_front();
         check({tag, "_ack"}, 32'(oa), 32'(ea));
      end
      obs_ack.delete();
      exp_ack.delete();
   endtask

   // One slot of n SCLK periods on the current channel; bits is the word left-aligned.
   task automatic send_slot(input int n, input logic [31:0] bits, input bit scramble,
                            input int rst_after);
      logic          ch, s;
      logic [31:0]   t;
      logic [SW-1:0] load_v;
      bit            bnd;
      rx_ev_t        ev;
      ch      = next_ch;
      next_ch = ~next_ch;
      bnd     = 1'b0;
      load_v  = '0;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         sclk  = 1'b0;
         lrclk = ch;
         if (k == 0) begin
            sdin = pending;
         end else begin
            t    = bits << (k - 1);
            sdin = t[31];
         end
         if (k == 0 && ch != last_lr) begin
            bnd = 1'b1;
            if (m_synced) begin
               ev.ch       = prev_ch;
               ev.short_f  = (prev_n < SW);
               ev.data     = SW'((prev_bits & slot_mask(prev_n)) >> (32 - SW));
               exp_rx.push_back(ev);
               lb_m[prev_ch] = ev.data;
            end
            load_v = lb_on ? lb_m[ch] : (ch ? tx_data1 : tx_data0);
            if (!lb_on) exp_ack.push_back(ch ? 2'b10 : 2'b01);
            m_synced = 1'b1;
         end
         if (k == 0) last_lr = ch;
         if (scramble && k == n / 2) begin
            if (ch) tx_data1 = SW'($urandom);
            else    tx_data0 = SW'($urandom);
         end
         repeat (4) @(negedge clk);
         s    = sdout;
         sclk = 1'b1;
         cap  = cap | (32'(s) << (31 - cap_n));
         cap_n++;
         if (k == 0) begin
            if (cap_valid) check("tx_word", cap, cap_exp);
            cap       = '0;
            cap_n     = 0;
            cap_valid = bnd;
            cap_exp   = 32'({load_v, 8'h00}) & slot_mask(n);
         end
         if (k == rst_after) begin
            repeat (2) @(negedge clk);
            rst = 1'b1;
            repeat (2) @(negedge clk);
            check_all_zero("mid_reset");
            rst       = 1'b0;
            last_lr   = 1'b0;
            m_synced  = 1'b0;
            cap_valid = 1'b0;
            lb_m[0]   = '0;
            lb_m[1]   = '0;
         end
         repeat (3) @(negedge clk);
      end
      prev_ch   = ch;
      prev_n    = n;
      prev_bits = bits;
      t         = bits << (n - 1);
      pending   = t[31];
   endtask

   initial begin
      rst = 1'b1; sclk = 1'b0; lrclk = 1'b0; sdin = 1'b0;
      tx_data0 = '0; tx_data1 = '0;
`ifdef I2S_TARGET_LOOPBACK_EN
      loopback = 1'b0;
`endif
      next_ch = 1'b0; last_lr = 1'b0; pending = 1'b0; prev_ch = 1'b0;
      m_synced = 1'b0; lb_on = 1'b0; cap_valid = 1'b0;
      prev_n = 0; cap_n = 0; prev_bits = '0; cap = '0; cap_exp = '0;
      lb_m[0] = '0; lb_m[1] = '0;
      sdout_seen = 1'b0;

      $display("[TB] reset and first boundary");
      repeat (4) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;
      tx_data0 = SW'($urandom);
      tx_data1 = SW'($urandom);
      send_slot(32, $urandom, 1'b1, -1);
      check("presync_synced", 32'(synced), 32'd0);
      check("presync_sdout", 32'(sdout_seen), 32'd0);
      send_slot(32, $urandom, 1'b1, -1);
      check("sync_synced", 32'(synced), 32'd1);
      check_queues("sync");

      $display("[TB] receive both channels");
      send_slot(32, {24'hA5C3F0, 8'($urandom)}, 1'b1, -1);
      send_slot(32, {24'h123456, 8'($urandom)}, 1'b1, -1);
      send_slot(32, $urandom, 1'b1, -1);
      check_queues("rx_pair");

      $display("[TB] transmit fixed words");
      tx_data0 = 24'h800001;
      tx_data1 = 24'h7FFFFE;
      for (int i = 0; i < 4; i++) send_slot(32, $urandom, 1'b0, -1);
      check_queues("tx_fixed");

      $display("[TB] slot width edges");
      send_slot(24, 32'hFFFFFF00, 1'b1, -1);
      send_slot(24, 32'hFFFFFF00, 1'b1, -1);
      send_slot(16, 32'hBEEF0000, 1'b1, -1);
      send_slot(16, 32'hBEEF0000, 1'b1, -1);
      send_slot(32, $urandom, 1'b1, -1);
      check_queues("slot_edges");

      $display("[TB] random slots");
      for (int i = 0; i < 8; i++) send_slot(int'($urandom_range(16, 32)), $urandom, 1'b1, -1);
      check_queues("random");

      $display("[TB] reset mid-frame");
      send_slot(32, $urandom, 1'b1, 10);
      send_slot(32, $urandom, 1'b1, -1);
      check("resync_synced", 32'(synced), 32'd1);
      for (int i = 0; i < 3; i++) send_slot(32, $urandom, 1'b1, -1);
      check_queues("resync");

`ifdef I2S_TARGET_LOOPBACK_EN
      $display("[TB] loopback");
      loopback = 1'b1;
      lb_on    = 1'b1;
      send_slot(32, $urandom, 1'b1, -1);
      send_slot(32, {24'h00FF00, 8'h00}, 1'b1, -1);
      send_slot(32, $urandom, 1'b1, -1);
      send_slot(32, $urandom, 1'b1, -1);
      send_slot(32, $urandom, 1'b1, -1);
      check_queues("loopback");
      loopback = 1'b0;
      lb_on    = 1'b0;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
